pedestrian_request_latch: RTL and testbench
===========================================

PEDESTRIAN_REQUEST_LATCH -- requirements
Module: pedestrian_request_latch

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required to accept a key level change; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: not_keys  input  3  raw active-low push buttons, asynchronous; [0] southbound left, [1] NS walk, [2] EW walk.
REQ-005 SHALL have port: served  input  3  level from the traffic FSM, high while the matching phase is granted; same bit order as not_keys.
REQ-006 SHALL have port: request  output  3  registered latched pending request per channel; same bit order.
REQ-007 SHALL have port: walk_request  output  1  request[1] OR request[2], registered.
REQ-008 SHALL have port: key_level  output  3  registered debounced active-high key state, for debug LEDs.

Function
REQ-009 SHALL invert each not_keys bit and pass it through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce per channel: an 8-bit counter increments while the synchronized level differs from key_level, clears when they agree, and key_level toggles and the counter clears on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-011 SHALL detect a press as a key_level 0->1 transition, registered one cycle after the key_level change.
REQ-012 SHALL implement a per-channel FSM with states IDLE, PENDING and LOCKOUT; request bit = 1 only in PENDING.
REQ-013 IDLE->PENDING on a press; the served level is ignored in IDLE.
REQ-014 PENDING->IDLE when served=1 and key_level=0; PENDING->LOCKOUT when served=1 and key_level=1; otherwise the FSM stays in PENDING.
REQ-015 LOCKOUT->IDLE when key_level=0; a key held through service SHALL NOT re-request.
REQ-016 A press and served=1 in the same cycle in IDLE SHALL go to PENDING (served is only meaningful in PENDING).
REQ-017 Latency: key held stably low from edge k SHALL give key_level=1 after edge k+1+DEBOUNCE_CYCLES and request=1 after edge k+2+DEBOUNCE_CYCLES.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change key_level or request.
REQ-019 walk_request SHALL update on the same edge as the request bits.
REQ-020 The three channels SHALL be fully independent; simultaneous presses on all three SHALL set all three requests on the same edge.

Reset
REQ-021 On reset=1 at an edge, synchronizers, counters and key_level SHALL clear to 0, every FSM SHALL enter IDLE, and request and walk_request SHALL be 0.
REQ-022 Reset asserted mid-debounce or in PENDING SHALL discard that request; a key still held after reset SHALL be re-debounced and SHALL produce a new request.

Structure
REQ-023 The shared package traffic_pkg SHALL hold the channel-state enum (IDLE, PENDING, LOCKOUT), channel index constants (CH_SB_LEFT=0, CH_NS_WALK=1, CH_EW_WALK=2) and the default DEBOUNCE_CYCLES.
REQ-024 SHALL instantiate the sub-module request_channel three times; request_channel contains the synchronizer, debounce counter, edge detect and FSM for one key.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Hold not_keys[1]=0 from edge 10 -> key_level[1]=1 after edge 15; request[1]=1 and walk_request=1 after edge 16.
REQ-026 3-cycle low pulse on not_keys[2] -> key_level and request remain 000 throughout.
REQ-027 request[0]=1 with key released, then served[0]=1 for 1 cycle -> request[0]=0 on the next edge; a later press re-sets it.
REQ-028 served[1]=1 while key 1 is still held -> LOCKOUT, request[1] stays 0 while held; after release and a re-press, request[1]=1 at the expected latency.
REQ-029 All three keys pressed on the same edge -> request=111 on a single edge; then reset for 1 cycle with keys held -> request=000, and request returns to 111 six edges after reset deasserts.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared channel state, channel indices and debounce default
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } chan_state_e;

  localparam int unsigned CH_SB_LEFT = 0;
  localparam int unsigned CH_NS_WALK = 1;
  localparam int unsigned CH_EW_WALK = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/request_channel.sv
// rtl/request_channel.sv - one key: synchronizer, debounce, press detect, request FSM
module request_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic not_key,
  input  logic served,
  output logic key_level,
  output logic request,
  output logic request_next
);

  localparam logic [7:0] COUNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic        sync_meta;
  logic        sync_level;
  logic        key_prev;
  logic        press;
  logic [7:0]  count;
  chan_state_e state;
  chan_state_e state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      count      <= '0;
      key_level  <= 1'b0;
      key_prev   <= 1'b0;
      state      <= IDLE;
      request    <= 1'b0;
    end else begin
      sync_meta  <= ~not_key;
      sync_level <= sync_meta;
      if (sync_level == key_level) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        count     <= '0;
        key_level <= ~key_level;
      end else begin
        count <= count + 8'd1;
      end
      key_prev <= key_level;
      state    <= state_next;
      request  <= request_next;
    end
  end

  // Press is derived from registered levels, so it lands one cycle after key_level rises.
  assign press = key_level & ~key_prev;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press) state_next = PENDING;
      PENDING: if (served) state_next = key_level ? LOCKOUT : IDLE;
      LOCKOUT: if (!key_level) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign request_next = (state_next == PENDING);

endmodule

// File: rtl/pedestrian_request_latch.sv
// rtl/pedestrian_request_latch.sv - three independent debounced, latched pedestrian requests
module pedestrian_request_latch
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] not_keys,
  input  logic [2:0] served,
  output logic [2:0] request,
  output logic       walk_request,
  output logic [2:0] key_level
);

  logic [2:0] request_next;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    request_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .not_key     (not_keys[i]),
      .served      (served[i]),
      .key_level   (key_level[i]),
      .request     (request[i]),
      .request_next(request_next[i])
    );
  end

  // Built from next-state so it changes on the same edge as the request bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      walk_request <= 1'b0;
    end else begin
      walk_request <= request_next[CH_NS_WALK] | request_next[CH_EW_WALK];
    end
  end

endmodule

// File: tb/tb_pedestrian_request_latch.sv
// tb/tb_pedestrian_request_latch.sv - directed and randomized checks against a behavioural model
module tb_pedestrian_request_latch;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] not_keys;
  logic [2:0] served;
  logic [2:0] request;
  logic       walk_request;
  logic [2:0] key_level;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_s1, m_s2, m_kl, m_klp, m_pend, m_lock;
  logic       m_walk;
  int         m_run [3];

  pedestrian_request_latch #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .not_keys    (not_keys),
    .served      (served),
    .request     (request),
    .walk_request(walk_request),
    .key_level   (key_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_kl = '0; m_klp = '0; m_pend = '0; m_lock = '0;
    m_walk = 1'b0;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
  endtask

  // A key level is accepted once the twice-delayed sample has disagreed for D cycles in a row.
  task automatic model_edge(input logic [2:0] nk, input logic [2:0] sv, input logic rst);
    logic old_kl, press;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
      old_kl = m_kl[c];
      if (m_s2[c] != old_kl) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_kl[c]  = ~old_kl;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      press    = old_kl & ~m_klp[c];
      m_klp[c] = old_kl;
      m_s2[c]  = m_s1[c];
      m_s1[c]  = ~nk[c];
      if (m_lock[c]) begin
        if (!old_kl) m_lock[c] = 1'b0;
      end else if (m_pend[c]) begin
        if (sv[c]) begin
          m_pend[c] = 1'b0;
          m_lock[c] = old_kl;
        end
      end else if (press) begin
        m_pend[c] = 1'b1;
      end
    end
    m_walk = m_pend[1] | m_pend[2];
  endtask

  task automatic step(input logic [2:0] nk, input logic [2:0] sv, input logic rst);
    not_keys = nk;
    served   = sv;
    reset    = rst;
    @(posedge clk);
    model_edge(nk, sv, rst);
    #1;
    chk("model_key_level", 8'(key_level), 8'(m_kl));
    chk("model_request", 8'(request), 8'(m_pend));
    chk("model_walk", 8'(walk_request), 8'(m_walk));
  endtask

  logic [2:0] rnd_nk;
  logic [2:0] rnd_sv;

  initial begin
    model_reset();
    not_keys = 3'b111;
    served   = 3'b000;
    reset    = 1'b1;

    step(3'b111, 3'b000, 1'b1);
    step(3'b111, 3'b000, 1'b1);
    chk("reset_request", 8'(request), 8'h0);
    chk("reset_walk", 8'(walk_request), 8'h0);
    chk("reset_key_level", 8'(key_level), 8'h0);
    step(3'b111, 3'b000, 1'b0);

    // NS walk key held: key_level at edge k+1+D, request/walk one edge later
    for (int i = 0; i <= D + 1; i++) begin
      step(3'b101, 3'b000, 1'b0);
      chk("kl1_latency", 8'(key_level[1]), 8'(i == D + 1));
      chk("req1_before", 8'(request[1]), 8'h0);
    end
    step(3'b101, 3'b000, 1'b0);
    chk("req1_latency", 8'(request[1]), 8'h1);
    chk("walk_latency", 8'(walk_request), 8'h1);

    // served while still held: lockout, no re-request while held
    step(3'b101, 3'b010, 1'b0);
    chk("lockout_req1", 8'(request[1]), 8'h0);
    repeat (8) begin
      step(3'b101, 3'b000, 1'b0);
      chk("lockout_hold", 8'(request[1]), 8'h0);
    end
    repeat (D + 4) step(3'b111, 3'b000, 1'b0);
    chk("lockout_release", 8'(request[1]), 8'h0);
    for (int i = 0; i <= D + 2; i++) begin
      step(3'b101, 3'b000, 1'b0);
      chk("repress_req1", 8'(request[1]), 8'(i == D + 2));
    end
    repeat (D + 4) step(3'b111, 3'b000, 1'b0);
    step(3'b111, 3'b010, 1'b0);
    chk("serve_released_req1", 8'(request[1]), 8'h0);

    // SB-left: released before service, one-cycle served clears it, new press re-sets it
    repeat (D + 3) step(3'b110, 3'b000, 1'b0);
    chk("req0_set", 8'(request[0]), 8'h1);
    chk("walk_not_sb", 8'(walk_request), 8'h0);
    repeat (D + 4) step(3'b111, 3'b000, 1'b0);
    chk("req0_latched", 8'(request[0]), 8'h1);
    step(3'b111, 3'b001, 1'b0);
    chk("req0_served", 8'(request[0]), 8'h0);
    step(3'b111, 3'b000, 1'b0);
    chk("req0_stays_clear", 8'(request[0]), 8'h0);
    repeat (D + 3) step(3'b110, 3'b000, 1'b0);
    chk("req0_reset_again", 8'(request[0]), 8'h1);
    repeat (D + 4) step(3'b111, 3'b000, 1'b0);
    step(3'b111, 3'b001, 1'b0);

    // short glitch on EW walk is rejected
    repeat (D - 1) step(3'b011, 3'b000, 1'b0);
    repeat (D + 6) begin
      step(3'b111, 3'b000, 1'b0);
      chk("glitch_kl", 8'(key_level), 8'h0);
      chk("glitch_req", 8'(request), 8'h0);
    end

    // all three together, then reset with keys held forces a fresh debounce
    for (int i = 0; i <= D + 2; i++) begin
      step(3'b000, 3'b000, 1'b0);
      chk("all_press", 8'(request), (i == D + 2) ? 8'h7 : 8'h0);
    end
    step(3'b000, 3'b000, 1'b1);
    chk("mid_reset_req", 8'(request), 8'h0);
    chk("mid_reset_kl", 8'(key_level), 8'h0);
    for (int j = 1; j <= D + 3; j++) begin
      step(3'b000, 3'b000, 1'b0);
      chk("after_reset", 8'(request), (j == D + 3) ? 8'h7 : 8'h0);
    end

    // random key levels with run lengths around the debounce window
    rnd_nk = 3'b111;
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 6) == 0) rnd_nk[c] = ~rnd_nk[c];
        rnd_sv[c] = ($urandom_range(0, 5) == 0);
      end
      step(rnd_nk, rnd_sv, $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
